// File: rtl/mem_axi_slave_model.sv
// mem_axi_slave_model
//   INCR-only AXI4 memory responder backed by a C_MEM_DEPTH x C_M_AXI_DATA_WIDTH
//   array. The write and read channels run as independent FSMs, each with one
//   outstanding burst. Write responses are always OKAY, so there is no resp port.
//
// Ports
//   aclk, areset_n            clock, async active-low reset
//   s_axi_aw*                 write address (valid/ready/addr/len)
//   s_axi_w*                  write data (valid/ready/data/strb/last)
//   s_axi_b*                  write response (valid/ready)
//   s_axi_ar*                 read address (valid/ready/addr/len)
//   s_axi_r*                  read data (valid/ready/data/last)
//   wlast_err                 sticky: wlast disagreed with the beat count
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready high, waiting for a burst address
//   W_DATA | wready high, accepting beats until count == awlen
//   W_RESP | bvalid high until bready
//
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for a burst address
//   R_DATA | rvalid high, presenting the current beat until accepted

module mem_axi_slave_model #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH        = 1024
) (
  input  logic                              aclk,
  input  logic                              areset_n,

  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                        s_axi_awlen,

  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wlast,

  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,

  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                        s_axi_arlen,

  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic                              s_axi_rlast,

  output logic                              wlast_err
);

  localparam int LP_DW_BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int LP_OFS      = $clog2(LP_DW_BYTES);
  localparam int LP_IW       = $clog2(C_MEM_DEPTH);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  logic [C_M_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

  w_state_t         w_state, w_next;
  r_state_t         r_state, r_next;

  logic [LP_IW-1:0] w_idx;
  logic [7:0]       w_cnt;
  logic [7:0]       w_len;
  logic [LP_IW-1:0] r_idx;
  logic [7:0]       r_cnt;
  logic [7:0]       r_len;

  logic [LP_IW-1:0] aw_idx;
  logic [LP_IW-1:0] ar_idx;
  logic             aw_fire;
  logic             w_fire;
  logic             w_end;
  logic             ar_fire;
  logic             r_fire;

  // Byte-lane offset bits and anything above the index range are dropped;
  // out-of-range addresses simply alias modulo the depth.
  assign aw_idx  = s_axi_awaddr[LP_OFS +: LP_IW];
  assign ar_idx  = s_axi_araddr[LP_OFS +: LP_IW];

  assign aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_fire  = s_axi_wvalid  && s_axi_wready;
  assign w_end   = (w_cnt == w_len);
  assign ar_fire = s_axi_arvalid && s_axi_arready;
  assign r_fire  = s_axi_rvalid  && s_axi_rready;

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) w_state <= W_IDLE;
    else           w_state <= w_next;
  end

  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        // Burst length comes from awlen only; wlast is just cross-checked.
        if (s_axi_wvalid && w_end) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_idx     <= '0;
      w_cnt     <= '0;
      w_len     <= '0;
      wlast_err <= 1'b0;
    end else begin
      if (aw_fire) begin
        w_idx <= aw_idx;
        w_cnt <= '0;
        w_len <= s_axi_awlen;
      end else if (w_fire) begin
        w_idx <= w_idx + 1'b1;
        w_cnt <= w_cnt + 8'd1;
        if (s_axi_wlast != w_end) wlast_err <= 1'b1;
      end
    end
  end

  // Backing store has no reset so a reset mid-test keeps its contents.
  always_ff @(posedge aclk) begin
    if (w_fire) begin
      for (int b = 0; b < LP_DW_BYTES; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read FSM
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_state <= R_IDLE;
    else           r_state <= r_next;
  end

  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready && s_axi_rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // rdata is fetched with a non-blocking read, so a word written on the same
  // edge it is fetched returns its old contents while the write still lands.
  // r_idx always points at the word to fetch for the next beat.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      s_axi_rdata <= '0;
      s_axi_rlast <= 1'b0;
    end else begin
      if (ar_fire) begin
        s_axi_rdata <= mem[ar_idx];
        s_axi_rlast <= (s_axi_arlen == 8'd0);
        r_idx       <= ar_idx + 1'b1;
        r_cnt       <= '0;
        r_len       <= s_axi_arlen;
      end else if (r_fire) begin
        if (s_axi_rlast) begin
          s_axi_rlast <= 1'b0;
        end else begin
          s_axi_rdata <= mem[r_idx];
          s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
          r_idx       <= r_idx + 1'b1;
          r_cnt       <= r_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: doc/mem_axi_slave_model.md
MEM_AXI_SLAVE_MODEL -- requirements
Module: mem_axi_slave_model

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 64, AXI byte-address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 512, AXI data width; LP_DW_BYTES = C_M_AXI_DATA_WIDTH/8.
REQ-003 SHALL have parameter C_MEM_DEPTH, default 1024, backing-store depth in data words (power of two).
REQ-004 Ports, listed as name, direction, width, meaning:
- aclk  in  1  single clock. All logic is on rising edge.
- areset_n  in  1  asynchronous, active-low reset.
- s_axi_awvalid/s_axi_awready  in/out  1  write-address handshake.
- s_axi_awaddr  in  C_M_AXI_ADDR_WIDTH  burst start byte address.
- s_axi_awlen  in  8  beats minus one.
- s_axi_wvalid/s_axi_wready  in/out  1  write-data handshake.
- s_axi_wdata  in  C_M_AXI_DATA_WIDTH  write beat.
- s_axi_wstrb  in  LP_DW_BYTES  byte enables.
- s_axi_wlast  in  1  last write beat.
- s_axi_bvalid/s_axi_bready  out/in  1  write-response handshake (OKAY only, no resp port).
- s_axi_arvalid/s_axi_arready  in/out  1  read-address handshake.
- s_axi_araddr  in  C_M_AXI_ADDR_WIDTH  burst start byte address.
- s_axi_arlen  in  8  beats minus one.
- s_axi_rvalid/s_axi_rready  out/in  1  read-data handshake.
- s_axi_rdata  out  C_M_AXI_DATA_WIDTH  read beat.
- s_axi_rlast  out  1  last read beat.
- wlast_err  out  1  sticky protocol-error flag.

Function
REQ-005 SHALL implement an INCR-only AXI4 responder with a C_MEM_DEPTH x C_M_AXI_DATA_WIDTH array. The word index is (addr / LP_DW_BYTES) mod C_MEM_DEPTH. The index increments by 1 per beat and wraps from C_MEM_DEPTH-1 to 0.
REQ-006 Write FSM states W_IDLE, W_DATA, W_RESP.
- s_axi_awready=1 only in W_IDLE.
- AW accept latches the index and a beat count of 0, then goes to W_DATA.
REQ-007 In W_DATA, s_axi_wready SHALL be 1.
- Each wvalid&&wready beat writes only the bytes whose wstrb bit is 1, then increments index and count.
- The beat with count==awlen ends the burst and moves to W_RESP on the next cycle.
REQ-008 Burst end SHALL be decided by the beat count alone.
- If wlast disagrees with count==awlen on any accepted beat, wlast_err SHALL set and hold until reset.
REQ-009 In W_RESP, s_axi_bvalid=1 and SHALL hold until bready.
- On bvalid&&bready the FSM returns to W_IDLE.
- Minimum AW-accept to next-AW-accept is awlen+3 cycles.
REQ-010 Read FSM states R_IDLE, R_DATA.
- s_axi_arready=1 only in R_IDLE.
- AR accept latches index, count 0 and arlen.
- s_axi_rvalid=1 with word[index] on the next cycle (1-cycle latency).
REQ-011 In R_DATA, s_axi_rdata/s_axi_rlast SHALL hold stable while rvalid && !rready.
- On rvalid&&rready the next word is presented on the following cycle with no bubble.
- s_axi_rlast=1 exactly on the beat with count==arlen.
- After that beat is accepted, the FSM returns to R_IDLE with rvalid=0.
REQ-012 Read and write FSMs SHALL run independently and concurrently, each with one outstanding burst.
REQ-013 A same-cycle write and read-fetch of the same word SHALL return the pre-write data; the write still commits.
REQ-014 Address bits below log2(LP_DW_BYTES) and above the index range SHALL be ignored; there is no error response.

Reset
REQ-015 When areset_n=0, both FSMs SHALL go to IDLE asynchronously.
- Outputs: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, rdata=0, wlast_err=0.
REQ-016 Reset mid-burst SHALL abandon the burst with no further beats or response; memory contents SHALL NOT be cleared.
REQ-017 Release of areset_n SHALL take effect on the first aclk rising edge after deassertion.

Verification
REQ-018 Write awaddr=0x40, awlen=3, four beats with data 0xA0..0xA3, full wstrb, wlast on beat 3 -> one bvalid. Then read araddr=0x40, arlen=3 -> rdata 0xA0..0xA3, rlast on beat 3, wlast_err=0.
REQ-019 Write word 0x00 with 0xFF..FF, then write 0x11..11 with wstrb=0x1 -> readback byte0=0x11, bytes1..63=0xFF.
REQ-020 With depth 1024: write awaddr=0xFFC0 (index 1023), awlen=1, data D0,D1 -> D0 at index 1023, D1 at index 0; read-back matches.
REQ-021 Read arlen=7 with rready toggling 1,0,0,1,... -> every beat is held stable while stalled, 8 beats in order, exactly one rlast.
REQ-022 Write awlen=1 with wlast on beat 0 -> wlast_err=1, burst still takes 2 beats, then bvalid; a later clean burst leaves wlast_err=1.
REQ-023 Assert areset_n=0 mid read burst (after 2 of 4 beats) -> rvalid=0 immediately; after release arready=1 and stored memory is unchanged.
